// File: rtl/shift_reg_param.sv
// rtl/shift_reg_param.sv - parametrised universal shift register with multi-cycle shift-by-N
//
// Purpose:
//   Universal shift register (SLL, SRL, SRA, ROL, ROR) with single-step shifting
//   and a multi-cycle shift-by-N operation using a start/busy/done handshake.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   init       in   1      synchronous clear of data and any running operation
//   Ld         in   1      parallel load of dataIn (aborts a running operation)
//   dataIn     in   WIDTH  parallel load value
//   mode       in   3      000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others hold
//   sh_en      in   1      single-step shift in the live mode
//   serIn      in   1      fill bit for SLL/SRL
//   start      in   1      begin multi-cycle shift by sh_amt
//   sh_amt     in   CNT_W  shift count, sampled with start
//   dataOut    out  WIDTH  register contents
//   serOut_msb out  1      dataOut[WIDTH-1]
//   serOut_lsb out  1      dataOut[0]
//   busy       out  1      multi-cycle operation in progress
//   done       out  1      one-cycle completion pulse

module shift_reg_param #(
  parameter int WIDTH = 17,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             Ld,
  input  logic [WIDTH-1:0] dataIn,
  input  logic [2:0]       mode,
  input  logic             sh_en,
  input  logic             serIn,
  input  logic             start,
  input  logic [CNT_W-1:0] sh_amt,
  output logic [WIDTH-1:0] dataOut,
  output logic             serOut_msb,
  output logic             serOut_lsb,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] dataReg;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       latMode;
  logic             busyReg;
  logic             doneReg;

  // One shift position in the given mode; reserved modes hold the data.
  function automatic logic [WIDTH-1:0] stepOnce(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       m,
    input logic             fill
  );
    logic [WIDTH-1:0] r;
    case (m)
      3'b000:  r = {d[WIDTH-2:0], fill};
      3'b001:  r = {fill, d[WIDTH-1:1]};
      3'b010:  r = {d[WIDTH-1], d[WIDTH-1:1]};
      3'b011:  r = {d[WIDTH-2:0], d[WIDTH-1]};
      3'b100:  r = {d[0], d[WIDTH-1:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      dataReg <= '0;
      cnt     <= '0;
      latMode <= 3'b000;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      // done is a pulse: only the completing branches below raise it.
      doneReg <= 1'b0;
      if (init) begin
        dataReg <= '0;
        busyReg <= 1'b0;
        cnt     <= '0;
      end else if (Ld) begin
        dataReg <= dataIn;
        busyReg <= 1'b0;
        cnt     <= '0;
      end else if (busyReg) begin
        // Latched mode for the shift direction, live serIn for the fill.
        dataReg <= stepOnce(dataReg, latMode, serIn);
        cnt     <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busyReg <= 1'b0;
          doneReg <= 1'b1;
        end
      end else if (start) begin
        latMode <= mode;
        if (sh_amt == '0) begin
          doneReg <= 1'b1;
        end else begin
          busyReg <= 1'b1;
          cnt     <= sh_amt;
        end
      end else if (sh_en) begin
        dataReg <= stepOnce(dataReg, mode, serIn);
      end
    end
  end

  assign dataOut    = dataReg;
  assign serOut_msb = dataReg[WIDTH-1];
  assign serOut_lsb = dataReg[0];
  assign busy       = busyReg;
  assign done       = doneReg;

endmodule

// File: tb/tb_shift_reg_param.sv
// tb/tb_shift_reg_param.sv - directed self-checking bench for shift_reg_param

module tb_shift_reg_param;

  localparam int WIDTH = 17;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             init;
  logic             Ld;
  logic [WIDTH-1:0] dataIn;
  logic [2:0]       mode;
  logic             sh_en;
  logic             serIn;
  logic             start;
  logic [CNT_W-1:0] sh_amt;
  logic [WIDTH-1:0] dataOut;
  logic             serOut_msb;
  logic             serOut_lsb;
  logic             busy;
  logic             done;

  int errCnt = 0;
  int chkCnt = 0;
  int edges;
  int doneSeen;

  shift_reg_param #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .Ld         (Ld),
    .dataIn     (dataIn),
    .mode       (mode),
    .sh_en      (sh_en),
    .serIn      (serIn),
    .start      (start),
    .sh_amt     (sh_amt),
    .dataOut    (dataOut),
    .serOut_msb (serOut_msb),
    .serOut_lsb (serOut_lsb),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clearIns;
    init = 0; Ld = 0; sh_en = 0; start = 0;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    Ld = 1; dataIn = v;
    tick;
    Ld = 0;
  endtask

  initial begin
    rst = 1; init = 0; Ld = 0; dataIn = '0; mode = 3'b000; sh_en = 0;
    serIn = 0; start = 0; sh_amt = '0;
    tick;
    tick;
    checkVal("rst_data", dataOut, 0);
    checkVal("rst_busy", busy, 0);
    checkVal("rst_done", done, 0);
    rst = 0;
    tick;

    // 1: single-step SLL with serIn=1
    load(17'h12345);
    checkVal("t1_msb_before", serOut_msb, 1);
    mode = 3'b000; serIn = 1; sh_en = 1;
    tick;
    sh_en = 0;
    checkVal("t1_data", dataOut, 17'h0468B);
    checkVal("t1_msb_after", serOut_msb, 0);
    checkVal("t1_lsb_after", serOut_lsb, 1);
    checkVal("t1_done", done, 0);

    // single-step SRL with serIn=1, and reserved mode hold
    load(17'h00002);
    mode = 3'b001; serIn = 1; sh_en = 1;
    tick;
    checkVal("srl_step", dataOut, 17'h10001);
    mode = 3'b111;
    tick;
    sh_en = 0;
    checkVal("rsv_step", dataOut, 17'h10001);

    // 2: SRA by 4
    load(17'h10000);
    mode = 3'b010; sh_amt = 4; start = 1;
    tick;
    start = 0;
    mode = 3'b000;  // live mode change must not affect the running op
    checkVal("t2_busy_k", busy, 1);
    checkVal("t2_data_k", dataOut, 17'h10000);
    tick; checkVal("t2_d1", dataOut, 17'h18000); checkVal("t2_b1", busy, 1);
    tick; checkVal("t2_d2", dataOut, 17'h1C000);
    tick; checkVal("t2_d3", dataOut, 17'h1E000); checkVal("t2_b3", busy, 1);
    checkVal("t2_done3", done, 0);
    tick;
    checkVal("t2_data", dataOut, 17'h1F000);
    checkVal("t2_busy_end", busy, 0);
    checkVal("t2_done", done, 1);
    tick;
    checkVal("t2_done_pulse", done, 0);

    // 3: ROR by WIDTH restores value; ROL by 1
    load(17'h12345);
    mode = 3'b100; sh_amt = 17; start = 1;
    tick;
    start = 0;
    edges = 0;
    doneSeen = 0;
    while (edges < 40 && !done) begin
      tick;
      edges++;
      if (done && busy) checkVal("t3_overlap", 1, 0);
    end
    checkVal("t3_edges", edges, 17);
    checkVal("t3_data", dataOut, 17'h12345);
    mode = 3'b011; sh_amt = 1; start = 1;
    tick;
    start = 0;
    tick;
    checkVal("t3_rol", dataOut, 17'h0468B);
    checkVal("t3_rol_done", done, 1);

    // 4: sh_amt=0, then start+sh_en together
    tick;
    mode = 3'b000; sh_amt = 0; start = 1;
    tick;
    start = 0;
    checkVal("t4_busy", busy, 0);
    checkVal("t4_done", done, 1);
    checkVal("t4_data", dataOut, 17'h0468B);
    tick;
    checkVal("t4_done_pulse", done, 0);
    load(17'h00003);
    mode = 3'b000; serIn = 0; sh_amt = 2; start = 1; sh_en = 1;
    tick;
    start = 0; sh_en = 0;
    checkVal("t4_both_data", dataOut, 17'h00003);
    checkVal("t4_both_busy", busy, 1);
    tick;
    tick;
    checkVal("t4_both_end", dataOut, 17'h0000C);
    checkVal("t4_both_done", done, 1);

    // 5: init aborts a running op; start while busy ignored
    load(17'h00001);
    mode = 3'b000; serIn = 0; sh_amt = 8; start = 1;
    tick;
    start = 0;
    tick;
    start = 1; sh_amt = 2; sh_en = 1;
    tick;
    start = 0; sh_en = 0;
    tick;
    checkVal("t5_data3", dataOut, 17'h00008);
    checkVal("t5_busy3", busy, 1);
    init = 1;
    tick;
    init = 0;
    checkVal("t5_init_data", dataOut, 0);
    checkVal("t5_init_busy", busy, 0);
    for (int i = 0; i < 10; i++) begin
      if (done) doneSeen++;
      tick;
    end
    checkVal("t5_no_done", doneSeen, 0);

    // 6: rst raised between edges mid-op, then rst with Ld
    load(17'h00005);
    mode = 3'b011; sh_amt = 4; start = 1;
    tick;
    start = 0;
    tick;
    rst = 1;
    #2;
    checkVal("t6_hold_data", dataOut, 17'h0000A);
    checkVal("t6_hold_busy", busy, 1);
    tick;
    checkVal("t6_rst_data", dataOut, 0);
    checkVal("t6_rst_busy", busy, 0);
    checkVal("t6_rst_done", done, 0);
    Ld = 1; dataIn = 17'h1FFFF;
    tick;
    checkVal("t6_rst_ld", dataOut, 0);
    rst = 0;
    tick;
    checkVal("t6_ld_after", dataOut, 17'h1FFFF);
    clearIns;
    tick;

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
